// File: rtl/pkg_loader.sv
// Types and constants for the boot-time imem loader.
package pkg_loader;
    typedef enum logic [2:0] {LD_LEN, LD_DATA, LD_CSUM, LD_DONE, LD_ERROR} loader_state_t;
    localparam int LD_HDR_BYTES = 4;
endpackage

// File: rtl/pkg_parameters.sv
// System-wide architectural parameters shared by the cpu, imem and loader.
package pkg_parameters;
    localparam int XLEN              = 32;
    localparam int ILEN              = 32;
    localparam int IMEM_CAPACITY_KiB = 1;
endpackage

// File: rtl/loader_word_assembler.sv
// Little-endian byte-to-word assembler; word/word_valid are presented combinationally
// alongside the 4th byte so the caller can register them on the accepting edge.
module loader_word_assembler
    import pkg_loader::*;
(
    input  logic        clk,
    input  logic        clear,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic [31:0] word,
    output logic        word_valid
);
    logic [23:0] shreg;
    logic [1:0]  idx;

    always_ff @(posedge clk) begin
        if (clear) begin
            shreg <= '0;
            idx   <= '0;
        end else if (byte_valid) begin
            shreg <= {byte_data, shreg[23:8]};
            idx   <= idx + 2'd1;
        end
    end

    // First byte ends up in the LSB once three bytes have shifted right.
    assign word       = {byte_data, shreg};
    assign word_valid = byte_valid && (idx == 2'(LD_HDR_BYTES - 1));
endmodule

// File: rtl/imem_loader.sv
// Streams a length-prefixed, checksummed image into imem and holds the cpu in
// reset until the whole image has been written and verified.
module imem_loader
    import pkg_loader::*;
#(
    parameter int IMEM_CAPACITY_KiB = pkg_parameters::IMEM_CAPACITY_KiB,
    parameter int XLEN              = pkg_parameters::XLEN,
    parameter int ILEN              = pkg_parameters::ILEN
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            rx_valid_i,
    input  logic [7:0]      rx_data_i,
    output logic            rx_ready_o,
    output logic            imem_we_o,
    output logic [XLEN-1:0] imem_addr_o,
    output logic [ILEN-1:0] imem_wdata_o,
    output logic            cpu_rst_o,
    output logic            done_o,
    output logic            error_o
);
    localparam logic [31:0] CAP_WORDS = 32'(IMEM_CAPACITY_KiB * 256);

    loader_state_t state, state_n;
    logic [31:0]   len_q;
    logic [31:0]   word_cnt;
    logic [7:0]    csum;
    logic          accept;
    logic          asm_valid;
    logic [31:0]   asm_word;
    logic          write_fire;

    assign rx_ready_o = !rst_i && (state == LD_LEN || state == LD_DATA || state == LD_CSUM);
    assign accept     = rx_valid_i && rx_ready_o;
    assign write_fire = (state == LD_DATA) && asm_valid;

    // One assembler serves both the length header and the payload words.
    loader_word_assembler u_asm (
        .clk        (clk_i),
        .clear      (rst_i),
        .byte_valid (accept && (state == LD_LEN || state == LD_DATA)),
        .byte_data  (rx_data_i),
        .word       (asm_word),
        .word_valid (asm_valid)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) state <= LD_LEN;
        else       state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            LD_LEN: begin
                if (asm_valid) begin
                    if (asm_word > CAP_WORDS)  state_n = LD_ERROR;
                    else if (asm_word == '0)   state_n = LD_CSUM;
                    else                       state_n = LD_DATA;
                end
            end
            LD_DATA: begin
                if (asm_valid && (word_cnt + 32'd1 == len_q)) state_n = LD_CSUM;
            end
            LD_CSUM: begin
                if (accept) state_n = (rx_data_i == csum) ? LD_DONE : LD_ERROR;
            end
            default: state_n = state;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            imem_we_o    <= 1'b0;
            imem_addr_o  <= '0;
            imem_wdata_o <= '0;
            len_q        <= '0;
            word_cnt     <= '0;
            csum         <= '0;
            done_o       <= 1'b0;
            error_o      <= 1'b0;
            cpu_rst_o    <= 1'b1;
        end else begin
            imem_we_o <= write_fire;
            if (write_fire) begin
                imem_wdata_o <= ILEN'(asm_word);
                word_cnt     <= word_cnt + 32'd1;
            end
            // Address moves on only after the strobe cycle has used it.
            if (imem_we_o) imem_addr_o <= imem_addr_o + XLEN'(4);
            if (state == LD_LEN && asm_valid) len_q <= asm_word;
            if (state == LD_DATA && accept)   csum  <= csum + rx_data_i;
            done_o    <= (state_n == LD_DONE);
            error_o   <= (state_n == LD_ERROR);
            cpu_rst_o <= (state_n != LD_DONE);
        end
    end
endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: a table of whole-image loads plus hand-written
// sequences for strobe latency, header overflow and mid-load reset.
module tb_imem_loader;
    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        rx_valid_i = 1'b0;
    logic [7:0]  rx_data_i = 8'h00;
    logic        rx_ready_o;
    logic        imem_we_o;
    logic [31:0] imem_addr_o;
    logic [31:0] imem_wdata_o;
    logic        cpu_rst_o;
    logic        done_o;
    logic        error_o;

    int checks = 0;
    int errors = 0;

    imem_loader dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .rx_valid_i   (rx_valid_i),
        .rx_data_i    (rx_data_i),
        .rx_ready_o   (rx_ready_o),
        .imem_we_o    (imem_we_o),
        .imem_addr_o  (imem_addr_o),
        .imem_wdata_o (imem_wdata_o),
        .cpu_rst_o    (cpu_rst_o),
        .done_o       (done_o),
        .error_o      (error_o)
    );

    always #5 clk_i = ~clk_i;

    logic [31:0] wa_q[$];
    logic [31:0] wd_q[$];
    always @(negedge clk_i) begin
        if (imem_we_o === 1'b1) begin
            wa_q.push_back(imem_addr_o);
            wd_q.push_back(imem_wdata_o);
        end
    end

    typedef struct {
        logic [31:0] n;
        int          nw;
        logic [31:0] w [4];
        bit          send_csum;
        logic [7:0]  csum;
        bit          jit;
        int          exp_wr;
        bit          exp_done;
        bit          exp_err;
    } vec_t;

    vec_t vt [7];

    function automatic vec_t mk(logic [31:0] n, int nw, logic [31:0] w0, logic [31:0] w1,
                                logic [31:0] w2, bit sc, logic [7:0] cs, bit jit,
                                int ew, bit ed, bit ee);
        vec_t v;
        v.n = n; v.nw = nw;
        v.w[0] = w0; v.w[1] = w1; v.w[2] = w2; v.w[3] = 32'h0;
        v.send_csum = sc; v.csum = cs; v.jit = jit;
        v.exp_wr = ew; v.exp_done = ed; v.exp_err = ee;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", nm, act, exp);
        end
    endtask

    // Called just after a rising edge; leaves the bench #1 after the accepting edge.
    task automatic send_byte(input logic [7:0] b, input bit jit);
        if (jit) begin
            repeat ($urandom_range(0, 2)) begin
                rx_valid_i = 1'b0;
                rx_data_i  = 8'($urandom);
                @(posedge clk_i); #1;
            end
        end
        rx_valid_i = 1'b1;
        rx_data_i  = b;
        @(posedge clk_i); #1;
        rx_valid_i = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input bit jit);
        for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8], jit);
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        rx_valid_i = 1'b0;
        @(posedge clk_i); #1;
        @(posedge clk_i); #1;
        rst_i = 1'b0;
    endtask

    initial begin
        int base;

        // csum values hand-computed as the byte sum of the payload words.
        vt[0] = mk(32'd1,   1, 32'h00000013, 32'h0, 32'h0, 1, 8'h13, 0, 1, 1, 0);
        vt[1] = mk(32'd3,   3, 32'h00100093, 32'h00200113, 32'h002081B3, 1, 8'h2B, 1, 3, 1, 0);
        vt[2] = mk(32'd0,   0, 32'h0, 32'h0, 32'h0, 1, 8'h00, 0, 0, 1, 0);
        vt[3] = mk(32'd0,   0, 32'h0, 32'h0, 32'h0, 1, 8'h01, 0, 0, 0, 1);
        vt[4] = mk(32'd257, 0, 32'h0, 32'h0, 32'h0, 0, 8'h00, 0, 0, 0, 1);
        vt[5] = mk(32'd2,   2, 32'h11223344, 32'h00000001, 32'h0, 1, 8'hAC, 0, 2, 0, 1);
        vt[6] = mk(32'd1,   1, 32'hDEADBEEF, 32'h0, 32'h0, 1, 8'h38, 1, 1, 1, 0);

        // Reset values, sampled while rst_i is still high.
        rst_i = 1'b1;
        @(posedge clk_i); #1;
        @(posedge clk_i); #1;
        chk("rst_we",    32'(imem_we_o),  32'd0);
        chk("rst_addr",  imem_addr_o,     32'd0);
        chk("rst_wdata", imem_wdata_o,    32'd0);
        chk("rst_cpu",   32'(cpu_rst_o),  32'd1);
        chk("rst_done",  32'(done_o),     32'd0);
        chk("rst_err",   32'(error_o),    32'd0);
        chk("rst_ready", 32'(rx_ready_o), 32'd0);
        rst_i = 1'b0;
        #1;
        chk("post_rst_ready", 32'(rx_ready_o), 32'd1);

        for (int i = 0; i < 7; i++) begin
            do_reset();
            base = wa_q.size();
            send_word(vt[i].n, vt[i].jit);
            for (int j = 0; j < vt[i].nw; j++) send_word(vt[i].w[j], vt[i].jit);
            if (vt[i].send_csum) send_byte(vt[i].csum, vt[i].jit);
            repeat (2) @(posedge clk_i);
            #1;
            chk($sformatf("v%0d_nwr", i), 32'(wa_q.size() - base), 32'(vt[i].exp_wr));
            for (int j = 0; j < vt[i].exp_wr; j++) begin
                if (base + j < wa_q.size()) begin
                    chk($sformatf("v%0d_addr%0d", i, j), wa_q[base + j], 32'(4 * j));
                    chk($sformatf("v%0d_data%0d", i, j), wd_q[base + j], vt[i].w[j]);
                end
            end
            chk($sformatf("v%0d_done", i),  32'(done_o),     32'(vt[i].exp_done));
            chk($sformatf("v%0d_err", i),   32'(error_o),    32'(vt[i].exp_err));
            chk($sformatf("v%0d_cpu", i),   32'(cpu_rst_o),  32'(!vt[i].exp_done));
            chk($sformatf("v%0d_ready", i), 32'(rx_ready_o), 32'd0);
        end

        // Strobe and done latency, one byte per cycle.
        do_reset();
        send_word(32'd1, 0);
        send_byte(8'h13, 0); send_byte(8'h00, 0); send_byte(8'h00, 0);
        chk("lat_we_early", 32'(imem_we_o), 32'd0);
        send_byte(8'h00, 0);
        chk("lat_we",    32'(imem_we_o), 32'd1);
        chk("lat_addr",  imem_addr_o,    32'd0);
        chk("lat_wdata", imem_wdata_o,   32'h00000013);
        @(posedge clk_i); #1;
        chk("lat_we_drop", 32'(imem_we_o), 32'd0);
        chk("lat_addr4",   imem_addr_o,    32'd4);
        chk("lat_done0",   32'(done_o),    32'd0);
        send_byte(8'h13, 0);
        chk("lat_done",  32'(done_o),    32'd1);
        chk("lat_cpu",   32'(cpu_rst_o), 32'd0);
        chk("lat_ready", 32'(rx_ready_o), 32'd0);
        // Terminal state ignores further bytes.
        base = wa_q.size();
        send_word(32'h12345678, 0);
        chk("done_hold", 32'(done_o), 32'd1);
        chk("done_nowr", 32'(wa_q.size() - base), 32'd0);

        // Length overflow flagged right after the 4th header byte.
        do_reset();
        send_byte(8'h01, 0); send_byte(8'h01, 0); send_byte(8'h00, 0);
        chk("ovf_err_early", 32'(error_o), 32'd0);
        send_byte(8'h00, 0);
        chk("ovf_err",   32'(error_o),    32'd1);
        chk("ovf_ready", 32'(rx_ready_o), 32'd0);
        chk("ovf_cpu",   32'(cpu_rst_o),  32'd1);

        // Reset after 6 payload bytes, with a byte offered on the reset edge.
        do_reset();
        send_word(32'd2, 0);
        send_word(32'hCAFEF00D, 0);
        send_byte(8'hAA, 0); send_byte(8'hBB, 0);
        base = wa_q.size();
        rst_i = 1'b1; rx_valid_i = 1'b1; rx_data_i = 8'h55;
        @(posedge clk_i); #1;
        chk("mid_we",    32'(imem_we_o),  32'd0);
        chk("mid_addr",  imem_addr_o,     32'd0);
        chk("mid_cpu",   32'(cpu_rst_o),  32'd1);
        chk("mid_ready", 32'(rx_ready_o), 32'd0);
        rst_i = 1'b0; rx_valid_i = 1'b0;
        send_word(32'd1, 0);
        send_word(32'hDEADBEEF, 0);
        send_byte(8'h38, 0);
        repeat (2) @(posedge clk_i);
        #1;
        chk("mid_nwr", 32'(wa_q.size() - base), 32'd1);
        if (wa_q.size() > base) begin
            chk("mid_waddr", wa_q[base], 32'd0);
            chk("mid_wdata", wd_q[base], 32'hDEADBEEF);
        end
        chk("mid_done", 32'(done_o),    32'd1);
        chk("mid_cpu0", 32'(cpu_rst_o), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
